// File: rtl/fir_llki_ctrl_pkg.sv
// Shared types and constants for the FIR LLKI key controller.
package llki_ctrl_pkg;

  localparam int unsigned KEY_WORD_W = 64;

  typedef enum logic [1:0] {
    OP_NOP       = 2'd0,
    OP_LOAD_KEY  = 2'd1,
    OP_CLEAR_KEY = 2'd2,
    OP_RSVD      = 2'd3
  } llki_op_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_ERR     = 2'd1,
    RSP_TIMEOUT = 2'd2
  } llki_status_e;

  typedef enum logic [1:0] {
    ST_LOCKED    = 2'd0,
    ST_LOADING   = 2'd1,
    ST_UNLOCKED  = 2'd2,
    ST_CLEARING  = 2'd3
  } llki_state_e;

endpackage

// File: rtl/fir_llki_ctrl_if.sv
// Command/response channel of the FIR LLKI key controller.
interface fir_llki_ctrl_if;
  import llki_ctrl_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [KEY_WORD_W-1:0] cmd_data;
  logic                  rsp_valid;
  logic [1:0]            rsp_status;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_status
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_status
  );

endinterface

// File: rtl/fir_llki_keyreg.sv
// Key storage: indexed word write and one-word-per-cycle clear.
// Word 0 is presented in the most significant bits of o_key.
module fir_llki_keyreg
  import llki_ctrl_pkg::*;
#(
  parameter int unsigned KEY_WORDS = 2,
  parameter int unsigned IDX_W     = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_wr_en,
  input  logic                            i_clr_en,
  input  logic [IDX_W-1:0]                i_idx,
  input  logic [KEY_WORD_W-1:0]           i_wr_data,
  output logic [KEY_WORD_W*KEY_WORDS-1:0] o_key
);

  logic [KEY_WORD_W-1:0] r_words [KEY_WORDS];

  // Write or zero the addressed word; clear wins if both are requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KEY_WORDS; i++) r_words[i] <= '0;
    end else begin
      for (int i = 0; i < KEY_WORDS; i++) begin
        if (i_idx == IDX_W'(i)) begin
          if (i_clr_en)     r_words[i] <= '0;
          else if (i_wr_en) r_words[i] <= i_wr_data;
        end
      end
    end
  end

  for (genvar g = 0; g < KEY_WORDS; g++) begin : g_pack
    assign o_key[KEY_WORD_W*(KEY_WORDS-g)-1 -: KEY_WORD_W] = r_words[g];
  end

endmodule

// File: rtl/fir_llki_ctrl.sv
// FIR LLKI key controller: command FSM, sample gating and post-unlock flush.
// Optional feature: define FIR_LLKI_CTRL_TIMEOUT_EN to abort an idle key load
// after TIMEOUT_CYC cycles with a TIMEOUT response.
module fir_llki_ctrl
  import llki_ctrl_pkg::*;
#(
  parameter int unsigned KEY_WORDS   = 2,
  parameter int unsigned FLUSH_CYC   = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  fir_llki_ctrl_if.slave                  bus,
  output logic [KEY_WORD_W*KEY_WORDS-1:0] o_key_out,
  output logic                            o_unlocked,
  input  logic [31:0]                     i_in_data,
  output logic [31:0]                     o_core_in_data,
  input  logic [31:0]                     i_core_out_data,
  output logic [31:0]                     o_out_data,
  output logic                            o_out_valid
);

  localparam int unsigned IDX_W = $clog2(KEY_WORDS + 1);
  localparam int unsigned FL_W  = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

  localparam logic [1:0] S_LOCKED   = ST_LOCKED;
  localparam logic [1:0] S_LOADING  = ST_LOADING;
  localparam logic [1:0] S_UNLOCKED = ST_UNLOCKED;
  localparam logic [1:0] S_CLEARING = ST_CLEARING;

  logic [1:0]       r_state, w_state_nx;
  logic [IDX_W-1:0] r_widx, w_widx_nx;
  logic [FL_W-1:0]  r_flush;
  logic             r_rsp_valid, w_rsp_valid_nx;
  logic [1:0]       r_rsp_status, w_rsp_status_nx;
  logic             w_accept, w_last_word, w_wr_en, w_clr_en, w_flush_load;
  logic             w_timeout_hit;

  assign bus.cmd_ready  = (r_state != S_CLEARING);
  assign w_accept       = bus.cmd_valid && bus.cmd_ready;
  assign w_last_word    = (r_widx == IDX_W'(KEY_WORDS - 1));
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_status = r_rsp_status;

`ifdef FIR_LLKI_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_idle;

  // Count consecutive LOADING cycles without an accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_idle <= '0;
    else if (r_state != S_LOADING || w_accept) r_idle <= '0;
    else                                    r_idle <= r_idle + TO_W'(1);
  end

  assign w_timeout_hit = (r_state == S_LOADING) && !w_accept &&
                         (r_idle == TO_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout_hit = 1'b0 & (TIMEOUT_CYC != 0);
`endif

  // Next-state, word index, response and key-store strobes.
  always_comb begin
    w_state_nx      = r_state;
    w_widx_nx       = r_widx;
    w_rsp_valid_nx  = 1'b0;
    w_rsp_status_nx = RSP_OK;
    w_wr_en         = 1'b0;
    w_clr_en        = 1'b0;
    w_flush_load    = 1'b0;
    if (r_state == S_CLEARING) begin
      w_clr_en  = 1'b1;
      w_widx_nx = r_widx + IDX_W'(1);
      if (w_last_word) begin
        w_state_nx = S_LOCKED;
        w_widx_nx  = '0;
      end
    end else if (w_accept) begin
      w_rsp_valid_nx = 1'b1;
      case (bus.cmd_op)
        OP_LOAD_KEY: begin
          if (r_state == S_UNLOCKED) begin
            w_rsp_status_nx = RSP_ERR;
          end else begin
            w_wr_en   = 1'b1;
            w_widx_nx = r_widx + IDX_W'(1);
            if (w_last_word) begin
              w_state_nx   = S_UNLOCKED;
              w_flush_load = 1'b1;
            end else begin
              w_state_nx = S_LOADING;
            end
          end
        end
        OP_CLEAR_KEY: begin
          w_state_nx = S_CLEARING;
          w_widx_nx  = '0;
        end
        OP_NOP:  w_rsp_status_nx = RSP_OK;
        default: w_rsp_status_nx = RSP_ERR;
      endcase
    end else if (w_timeout_hit) begin
      w_rsp_valid_nx  = 1'b1;
      w_rsp_status_nx = RSP_TIMEOUT;
      w_state_nx      = S_CLEARING;
      w_widx_nx       = '0;
    end
  end

  // FSM state, word index and the one-cycle response pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_LOCKED;
      r_widx       <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= RSP_OK;
    end else begin
      r_state      <= w_state_nx;
      r_widx       <= w_widx_nx;
      r_rsp_valid  <= w_rsp_valid_nx;
      r_rsp_status <= w_rsp_status_nx;
    end
  end

  // Flush counter masks FIR output for FLUSH_CYC cycles after unlock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_flush <= '0;
    else if (w_flush_load)                        r_flush <= FL_W'(FLUSH_CYC);
    else if (r_state == S_UNLOCKED && r_flush != '0) r_flush <= r_flush - FL_W'(1);
  end

  fir_llki_keyreg #(
    .KEY_WORDS (KEY_WORDS),
    .IDX_W     (IDX_W)
  ) u_keyreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_clr_en  (w_clr_en),
    .i_idx     (r_widx),
    .i_wr_data (bus.cmd_data),
    .o_key     (o_key_out)
  );

  assign o_unlocked     = (r_state == S_UNLOCKED);
  assign o_core_in_data = o_unlocked ? i_in_data : 32'd0;
  assign o_out_valid    = o_unlocked && (r_flush == '0);
  assign o_out_data     = o_out_valid ? i_core_out_data : 32'd0;

endmodule

// File: tb/tb_fir_llki_ctrl.sv
// Self-checking bench for fir_llki_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
// Define FIR_LLKI_CTRL_TIMEOUT_EN to also exercise the load timeout.
module tb_fir_llki_ctrl;
  import llki_ctrl_pkg::*;

  localparam int KW   = 2;
  localparam int FL   = 4;
  localparam int TO   = 8;
  localparam int KEYW = 64 * KW;

  localparam logic [63:0] K0 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K1 = 64'hFEDCBA9876543210;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [KEYW-1:0] keyOut;
  logic            unlocked;
  logic [31:0]     inData = 32'd0;
  logic [31:0]     coreInData;
  logic [31:0]     coreOutData = 32'd0;
  logic [31:0]     outData;
  logic            outValid;

  fir_llki_ctrl_if bus();

  fir_llki_ctrl #(.KEY_WORDS(KW), .FLUSH_CYC(FL), .TIMEOUT_CYC(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .o_key_out       (keyOut),
    .o_unlocked      (unlocked),
    .i_in_data       (inData),
    .o_core_in_data  (coreInData),
    .i_core_out_data (coreOutData),
    .o_out_data      (outData),
    .o_out_valid     (outValid)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: list of loaded words plus a few countdowns.
  logic [63:0] mWords [KW];
  int          mLoaded, mClearLeft, mFlushLeft, mIdle;
  bit          mUnlocked, mRsp;
  logic [1:0]  mStatus;

  typedef struct {
    logic            valid;
    logic [1:0]      op;
    logic [63:0]     data;
    logic            expRsp;
    logic [1:0]      expStatus;
    logic            expUnlocked;
    logic            expReady;
    logic [KEYW-1:0] expKey;
  } vec_t;

  vec_t vecs [10];

  logic        rv;
  logic [1:0]  rop;
  logic [63:0] rd;
  int          rsel;
  int          waited;
  bit          got;

  task automatic checkOutput(input string name, input logic [KEYW-1:0] actual,
                             input logic [KEYW-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [63:0] d);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [KEYW-1:0] modelKey();
    logic [KEYW-1:0] k;
    k = '0;
    for (int i = 0; i < KW; i++) k[KEYW-1-64*i -: 64] = mWords[i];
    return k;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < KW; i++) mWords[i] = '0;
    mLoaded = 0; mClearLeft = 0; mFlushLeft = 0; mIdle = 0;
    mUnlocked = 0; mRsp = 0; mStatus = 2'd0;
  endtask

  task automatic modelStep(input logic v, input logic [1:0] op, input logic [63:0] d);
    bit clearing, accept;
    clearing = (mClearLeft > 0);
    accept   = v && !clearing;
    mRsp     = 0;
    mStatus  = 2'd0;
    if (mUnlocked && mFlushLeft > 0) mFlushLeft--;
    if (clearing) begin
      mWords[KW - mClearLeft] = '0;
      mClearLeft--;
    end else if (accept) begin
      mRsp  = 1;
      mIdle = 0;
      case (op)
        2'd1: begin
          if (mUnlocked) mStatus = 2'd1;
          else begin
            mWords[mLoaded] = d;
            mLoaded++;
            if (mLoaded == KW) begin mUnlocked = 1; mFlushLeft = FL; end
          end
        end
        2'd2: begin mUnlocked = 0; mLoaded = 0; mClearLeft = KW; end
        2'd3: mStatus = 2'd1;
        default: ;
      endcase
    end
`ifdef FIR_LLKI_CTRL_TIMEOUT_EN
    else if (mLoaded > 0 && !mUnlocked) begin
      mIdle++;
      if (mIdle == TO) begin
        mRsp = 1; mStatus = 2'd2; mLoaded = 0; mClearLeft = KW; mIdle = 0;
      end
    end
`endif
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".ready"},    bus.cmd_ready, mClearLeft == 0);
    checkOutput({tag, ".rsp"},      bus.rsp_valid, mRsp);
    if (mRsp) checkOutput({tag, ".status"}, bus.rsp_status, mStatus);
    checkOutput({tag, ".unlocked"}, unlocked, mUnlocked);
    checkOutput({tag, ".key"},      keyOut, modelKey());
    checkOutput({tag, ".core_in"},  coreInData, mUnlocked ? inData : 32'd0);
    checkOutput({tag, ".out_valid"}, outValid, mUnlocked && mFlushLeft == 0);
    checkOutput({tag, ".out_data"}, outData,
                (mUnlocked && mFlushLeft == 0) ? coreOutData : 32'd0);
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, OP_NOP, 64'd0);
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.rsp",       bus.rsp_valid, 1'b0);
    checkOutput("reset.key",       keyOut, '0);
    checkOutput("reset.unlocked",  unlocked, 1'b0);
    checkOutput("reset.out_valid", outValid, 1'b0);
    checkOutput("reset.ready",     bus.cmd_ready, 1'b1);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, OP_LOAD_KEY,  K0,     1'b1, RSP_OK,  1'b0, 1'b1, {K0, 64'd0}};
    vecs[1] = '{1'b1, OP_LOAD_KEY,  K1,     1'b1, RSP_OK,  1'b1, 1'b1, {K0, K1}};
    vecs[2] = '{1'b1, OP_NOP,       64'd0,  1'b1, RSP_OK,  1'b1, 1'b1, {K0, K1}};
    vecs[3] = '{1'b1, OP_LOAD_KEY,  64'd1,  1'b1, RSP_ERR, 1'b1, 1'b1, {K0, K1}};
    vecs[4] = '{1'b0, OP_NOP,       64'd0,  1'b0, RSP_OK,  1'b1, 1'b1, {K0, K1}};
    vecs[5] = '{1'b1, OP_CLEAR_KEY, 64'd0,  1'b1, RSP_OK,  1'b0, 1'b0, {K0, K1}};
    vecs[6] = '{1'b0, OP_NOP,       64'd0,  1'b0, RSP_OK,  1'b0, 1'b0, {64'd0, K1}};
    vecs[7] = '{1'b0, OP_NOP,       64'd0,  1'b0, RSP_OK,  1'b0, 1'b1, '0};
    vecs[8] = '{1'b1, OP_RSVD,      64'd0,  1'b1, RSP_ERR, 1'b0, 1'b1, '0};
    vecs[9] = '{1'b1, OP_LOAD_KEY,  K1,     1'b1, RSP_OK,  1'b0, 1'b1, {K1, 64'd0}};

    $display("[TB] directed vector table");
    resetDut();
    inData = 32'h5;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].op, vecs[i].data);
      tick();
      checkOutput($sformatf("vec%0d.rsp", i), bus.rsp_valid, vecs[i].expRsp);
      if (vecs[i].expRsp)
        checkOutput($sformatf("vec%0d.status", i), bus.rsp_status, vecs[i].expStatus);
      checkOutput($sformatf("vec%0d.unlocked", i), unlocked, vecs[i].expUnlocked);
      checkOutput($sformatf("vec%0d.ready", i), bus.cmd_ready, vecs[i].expReady);
      checkOutput($sformatf("vec%0d.key", i), keyOut, vecs[i].expKey);
      checkOutput($sformatf("vec%0d.core_in", i), coreInData,
                  vecs[i].expUnlocked ? 32'h5 : 32'd0);
    end

    $display("[TB] flush window after unlock");
    resetDut();
    inData = 32'h5;
    coreOutData = 32'hCAFE0001;
    applyStimulus(1'b1, OP_LOAD_KEY, K0); tick();
    applyStimulus(1'b1, OP_LOAD_KEY, K1); tick();
    applyStimulus(1'b0, OP_NOP, 64'd0);
    checkOutput("flush.core_in", coreInData, 32'h5);
    for (int c = 0; c < FL; c++) begin
      checkOutput($sformatf("flush.masked%0d", c), outValid, 1'b0);
      checkOutput($sformatf("flush.data%0d", c), outData, 32'd0);
      tick();
    end
    checkOutput("flush.open", outValid, 1'b1);
    checkOutput("flush.open_data", outData, 32'hCAFE0001);
    coreOutData = 32'h12345678;
    #1;
    checkOutput("flush.follow_data", outData, 32'h12345678);
    applyStimulus(1'b1, OP_CLEAR_KEY, 64'd0); tick();
    applyStimulus(1'b0, OP_NOP, 64'd0);
    checkOutput("leave.out_valid", outValid, 1'b0);
    checkOutput("leave.out_data", outData, 32'd0);
    checkOutput("leave.core_in", coreInData, 32'd0);

    $display("[TB] reset during load");
    resetDut();
    applyStimulus(1'b1, OP_LOAD_KEY, K0); tick();
    applyStimulus(1'b1, OP_LOAD_KEY, K1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.rsp", bus.rsp_valid, 1'b0);
    checkOutput("midrst.key", keyOut, '0);
    tick();
    checkOutput("midrst.inflight_rsp", bus.rsp_valid, 1'b0);
    applyStimulus(1'b0, OP_NOP, 64'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("midrst.quiet", bus.rsp_valid, 1'b0);
    applyStimulus(1'b1, OP_LOAD_KEY, 64'hA5A5A5A55A5A5A5A); tick();
    applyStimulus(1'b0, OP_NOP, 64'd0);
    checkOutput("midrst.word0", keyOut, {64'hA5A5A5A55A5A5A5A, 64'd0});
    checkOutput("midrst.rsp_after", bus.rsp_valid, 1'b1);
    checkOutput("midrst.unlocked", unlocked, 1'b0);

`ifdef FIR_LLKI_CTRL_TIMEOUT_EN
    $display("[TB] load timeout");
    resetDut();
    applyStimulus(1'b1, OP_LOAD_KEY, K0); tick();
    applyStimulus(1'b0, OP_NOP, 64'd0);
    checkOutput("to.load_rsp", bus.rsp_valid, 1'b1);
    got = 0;
    waited = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      tick();
      if (bus.rsp_valid) begin got = 1; waited = c; end
    end
    checkOutput("to.seen", got, 1'b1);
    checkOutput("to.delay", waited, 8);
    checkOutput("to.status", bus.rsp_status, RSP_TIMEOUT);
    tick(); tick();
    checkOutput("to.key", keyOut, '0);
    checkOutput("to.ready", bus.cmd_ready, 1'b1);
    checkOutput("to.unlocked", unlocked, 1'b0);
`endif

    $display("[TB] randomized run against model");
    resetDut();
    for (int n = 0; n < 400; n++) begin
      rv   = ($urandom_range(0, 9) < 7);
      rsel = $urandom_range(0, 99);
      if (rsel < 55)      rop = OP_LOAD_KEY;
      else if (rsel < 75) rop = OP_NOP;
      else if (rsel < 88) rop = OP_CLEAR_KEY;
      else                rop = OP_RSVD;
      rd = {$urandom, $urandom};
      applyStimulus(rv, rop, rd);
      inData      = $urandom;
      coreOutData = $urandom;
      #2;
      checkAll($sformatf("rnd%0d", n));
      @(posedge clk);
      modelStep(rv, rop, rd);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fir_llki_ctrl.md
FIR_LLKI_CTRL -- requirements
Module: fir_llki_ctrl

Interface
REQ-001 SHALL have parameter KEY_WORDS, default 2: number of 64-bit key words; 2 gives a 128-bit key.
REQ-002 SHALL have parameter FLUSH_CYC, default 4: cycles of FIR output masking after unlock.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024: load-idle limit, used only under FIR_LLKI_CTRL_TIMEOUT_EN.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_op  in  2  0=NOP, 1=LOAD_KEY, 2=CLEAR_KEY, 3=reserved.
REQ-009 cmd_data  in  64  key word for LOAD_KEY.
REQ-010 rsp_valid  out  1  one-cycle response pulse.
REQ-011 rsp_status  out  2  0=OK, 1=ERR, 2=TIMEOUT.
REQ-012 key_out  out  64*KEY_WORDS  key to FIR core; word 0 in the MSBs.
REQ-013 unlocked  out  1  key fully loaded.
REQ-014 in_data  in  32  raw FIR sample.
REQ-015 core_in_data  out  32  sample to FIR core.
REQ-016 core_out_data  in  32  FIR core result.
REQ-017 out_data  out  32  gated result.
REQ-018 out_valid  out  1  out_data is usable.

Function
REQ-019 SHALL implement FSM states LOCKED, LOADING, UNLOCKED and CLEARING; reset state is LOCKED.
REQ-020 cmd_ready SHALL be 1 in LOCKED, LOADING and UNLOCKED, and 0 in CLEARING.
REQ-021 An accepted command SHALL produce rsp_valid exactly 1 cycle later, status as below.
REQ-022 LOAD_KEY in LOCKED or LOADING: write cmd_data to word index widx, increment widx, respond OK, and enter LOADING.
REQ-023 When widx reaches KEY_WORDS, the FSM SHALL enter UNLOCKED on the same edge.
REQ-024 LOAD_KEY in UNLOCKED SHALL respond ERR and leave key and state unchanged.
REQ-025 CLEAR_KEY in any accepting state SHALL respond OK, enter CLEARING and reset widx to 0.
REQ-026 CLEARING SHALL zero one key word per cycle (KEY_WORDS cycles), then return to LOCKED.
REQ-027 NOP SHALL respond OK with no state change.
REQ-028 Reserved op SHALL respond ERR with no state change.
REQ-029 unlocked SHALL be 1 only in UNLOCKED.
REQ-030 core_in_data SHALL be in_data when unlocked, otherwise 0 (combinational).
REQ-031 On entering UNLOCKED, a flush counter SHALL load FLUSH_CYC.
REQ-032 out_valid SHALL be 1 only when unlocked and the flush counter is 0.
REQ-033 out_data SHALL be core_out_data when out_valid, otherwise 0.
REQ-034 On leaving UNLOCKED, out_valid SHALL drop in the same cycle the state changes.

Reset
REQ-035 Asserting rst SHALL, asynchronously, set state LOCKED, widx 0, key_out 0, flush counter 0, rsp_valid 0, rsp_status 0, out_valid 0.
REQ-036 Reset mid-load or mid-clear SHALL discard partial key words; no response SHALL be issued for a command in flight.

Configuration
REQ-037 With FIR_LLKI_CTRL_TIMEOUT_EN defined: in LOADING, TIMEOUT_CYC consecutive cycles with no accepted command SHALL force CLEARING and pulse rsp_valid with TIMEOUT.
REQ-038 Without FIR_LLKI_CTRL_TIMEOUT_EN: LOADING SHALL persist indefinitely and TIMEOUT status SHALL never be produced.

Structure
REQ-039 Package llki_ctrl_pkg SHALL hold the op enum, the status enum, the FSM state enum and the key word width constant (64).
REQ-040 Key storage with indexed write and sequential clear SHALL live in sub-module fir_llki_keyreg; the FSM, gating and flush logic stay in fir_llki_ctrl.

Verification
REQ-041 Reset, then LOAD_KEY 0x0123456789ABCDEF then 0xFEDCBA9876543210 -> two OK responses, unlocked=1, key_out=0x0123456789ABCDEFFEDCBA9876543210.
REQ-042 After unlock with in_data=0x5 -> core_in_data=0x5; out_valid=0 for 4 cycles, then 1 with out_data equal to core_out_data.
REQ-043 While unlocked, LOAD_KEY 0x1 -> ERR response, key_out unchanged; CLEAR_KEY -> OK, cmd_ready=0 for 2 cycles, key_out=0, unlocked=0, core_in_data=0.
REQ-044 Reserved op 3 in LOCKED -> ERR, state unchanged; rst asserted after one LOAD_KEY -> key_out=0, next LOAD_KEY writes word 0.
REQ-045 With FIR_LLKI_CTRL_TIMEOUT_EN and TIMEOUT_CYC=8, one LOAD_KEY then idle -> TIMEOUT response 8 cycles later, key cleared, state LOCKED.
